// File: rtl/div_result_collector.sv
// Collects one result per divider operation (quotient or error code) into a
// first-word-fall-through FIFO with occupancy, hold and sticky lost flags.
module div_result_collector #(
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TMO   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     div_busy,
    input  logic                     div_valid,
    input  logic [DW-1:0]            quotient,
    input  logic                     dvz,
    input  logic                     ovf,
    input  logic                     out_ready,
    input  logic                     clr_lost,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [1:0]               out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     hold,
    output logic                     lost
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_dvz_q, err_dvz_d;
    logic            err_ovf_q, err_ovf_d;

    logic            push;
    logic [1:0]      push_err;
    logic [DW-1:0]   push_data;

    logic [DW+1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            hold_q, lost_q, lost_d;
    logic            full, pop, wr_en, drop;
    logic [DW+1:0]   head;

    // Monitor: exactly one push per division, whichever event ends it first.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        err_dvz_d = err_dvz_q;
        err_ovf_d = err_ovf_q;
        push      = 1'b0;
        push_err  = 2'b00;
        push_data = '0;
        unique case (state_q)
            StIdle: begin
                if (div_busy) begin
                    state_d   = StRun;
                    tmo_d     = '0;
                    err_dvz_d = 1'b0;
                    err_ovf_d = 1'b0;
                end
            end
            StRun: begin
                err_dvz_d = err_dvz_q | dvz;
                err_ovf_d = err_ovf_q | ovf;
                if (div_valid) begin
                    push      = 1'b1;
                    push_data = quotient;
                    state_d   = StDrain;
                end else if (!div_busy) begin
                    push     = 1'b1;
                    push_err = (err_dvz_q | dvz) ? 2'b01 :
                               (err_ovf_q | ovf) ? 2'b10 : 2'b11;
                    state_d  = StIdle;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    push     = 1'b1;
                    push_err = 2'b11;
                    state_d  = StDrain;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StDrain: begin
                if (!div_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign lost_d    = drop | (lost_q & ~clr_lost);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
    end

    // Resetting into StDrain means a division already in flight at release is skipped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StDrain;
            tmo_q     <= '0;
            err_dvz_q <= 1'b0;
            err_ovf_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            hold_q    <= 1'b0;
            lost_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            err_dvz_q <= err_dvz_d;
            err_ovf_q <= err_ovf_d;
            count_q   <= count_d;
            hold_q    <= (count_d == CW'(DEPTH));
            lost_q    <= lost_d;
            if (wr_en) begin
                mem_q[wptr_q] <= {push_err, push_data};
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
        end
    end

    assign head     = mem_q[rptr_q];
    assign out_data = out_valid ? head[DW-1:0] : '0;
    assign out_err  = out_valid ? head[DW+1:DW] : 2'b00;
    assign count    = count_q;
    assign hold     = hold_q;
    assign lost     = lost_q;

endmodule

// File: tb/tb_div_result_collector.sv
// Bench for div_result_collector: two instances (TMO=255 and TMO=8) share stimulus,
// each checked every cycle against a queue-based model plus literal spot checks.
module tb_div_result_collector;

    localparam int unsigned DW    = 10;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          busy, valid, dvz, ovf, rdy, clr;
    logic [DW-1:0] quo;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned TMO_G = (g == 0) ? 255 : 8;

        logic                   ov, oh, ol;
        logic [DW-1:0]          od;
        logic [1:0]             oe;
        logic [$clog2(DEPTH):0] oc;

        div_result_collector #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .TMO   (TMO_G)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .div_busy  (busy),
            .div_valid (valid),
            .quotient  (quo),
            .dvz       (dvz),
            .ovf       (ovf),
            .out_ready (rdy),
            .clr_lost  (clr),
            .out_valid (ov),
            .out_data  (od),
            .out_err   (oe),
            .count     (oc),
            .hold      (oh),
            .lost      (ol)
        );

        // Model: mode 0 waiting for a division, 1 division open, 2 waiting for busy low.
        logic [DW+1:0] mq[$];
        int            mode  = 2;
        int            runc  = 0;
        bit            edvz  = 0;
        bit            eovf  = 0;
        bit            mlost = 0;

        initial begin
            bit            pu, popd, drp;
            logic [DW+1:0] ent;
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) begin
                    mq.delete();
                    mode  = 2;
                    runc  = 0;
                    edvz  = 0;
                    eovf  = 0;
                    mlost = 0;
                end else begin
                    pu  = 0;
                    ent = '0;
                    case (mode)
                        0: if (busy) begin
                            mode = 1; runc = 0; edvz = 0; eovf = 0;
                        end
                        1: begin
                            if (valid) begin
                                pu = 1; ent = {2'b00, quo}; mode = 2;
                            end else if (!busy) begin
                                pu   = 1;
                                ent  = {(edvz || dvz) ? 2'b01 : (eovf || ovf) ? 2'b10 : 2'b11,
                                        {DW{1'b0}}};
                                mode = 0;
                            end else begin
                                runc++;
                                if (runc == int'(TMO_G)) begin
                                    pu = 1; ent = {2'b11, {DW{1'b0}}}; mode = 2;
                                end
                            end
                            if (dvz) edvz = 1;
                            if (ovf) eovf = 1;
                        end
                        default: if (!busy) mode = 0;
                    endcase
                    popd = (mq.size() > 0) && rdy;
                    drp  = pu && (mq.size() == int'(DEPTH)) && !popd;
                    if (popd) void'(mq.pop_front());
                    if (pu && !drp) mq.push_back(ent);
                    if (drp) mlost = 1;
                    else if (clr) mlost = 0;
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (!rst) begin
                    chk($sformatf("i%0d rst out_valid", g), ov, 0);
                    chk($sformatf("i%0d rst out_data", g), od, 0);
                    chk($sformatf("i%0d rst out_err", g), oe, 0);
                    chk($sformatf("i%0d rst count", g), oc, 0);
                    chk($sformatf("i%0d rst hold", g), oh, 0);
                    chk($sformatf("i%0d rst lost", g), ol, 0);
                end else begin
                    chk($sformatf("i%0d out_valid", g), ov, mq.size() != 0);
                    if (mq.size() != 0) begin
                        chk($sformatf("i%0d out_data", g), od, mq[0][DW-1:0]);
                        chk($sformatf("i%0d out_err", g), oe, mq[0][DW+1:DW]);
                    end
                    chk($sformatf("i%0d count", g), oc, mq.size());
                    chk($sformatf("i%0d hold", g), oh, mq.size() == int'(DEPTH));
                    chk($sformatf("i%0d lost", g), ol, mlost);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_div(input logic [DW-1:0] q, input logic r);
        busy = 1'b1;
        cyc();
        valid = 1'b1; quo = q; rdy = r;
        cyc();
        valid = 1'b0; rdy = 1'b0; busy = 1'b0;
        cyc();
    endtask

    task automatic pop_chk(input logic [DW-1:0] exp);
        chk("i0 fifo order", g_inst[0].od, exp);
        rdy = 1'b1;
        cyc();
        rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b0; busy = 1'b0; valid = 1'b0; dvz = 1'b0; ovf = 1'b0;
        rdy = 1'b0; clr = 1'b0; quo = '0;
        cyc(3);
        chk("reset count", g_inst[0].oc, 0);
        chk("reset out_valid", g_inst[0].ov, 0);
        rst = 1'b1;
        cyc(2);

        // 20 busy cycles then a valid result; instance 1 times out first.
        busy = 1'b1;
        cyc(20);
        chk("i0 no entry before push", g_inst[0].ov, 0);
        valid = 1'b1; quo = 10'd37;
        cyc();
        chk("i0 valid 1 cycle after push", g_inst[0].ov, 1);
        chk("i0 data 37", g_inst[0].od, 37);
        chk("i0 err ok", g_inst[0].oe, 0);
        valid = 1'b0;
        cyc(2);
        busy = 1'b0;
        cyc();
        chk("i0 single entry", g_inst[0].oc, 1);
        chk("i1 timeout entry", g_inst[1].oe, 3);
        chk("i1 single entry", g_inst[1].oc, 1);
        rdy = 1'b1; cyc(); rdy = 1'b0;

        // Error codes from busy falling without a valid.
        busy = 1'b1; dvz = 1'b1;
        cyc(2);
        busy = 1'b0; dvz = 1'b0;
        cyc();
        chk("dvz err", g_inst[0].oe, 1);
        chk("dvz data", g_inst[0].od, 0);
        rdy = 1'b1; cyc(); rdy = 1'b0;
        busy = 1'b1; cyc();
        ovf = 1'b1; cyc();
        ovf = 1'b0; cyc();
        busy = 1'b0; cyc();
        chk("ovf err", g_inst[0].oe, 2);
        rdy = 1'b1; cyc(); rdy = 1'b0;
        busy = 1'b1; cyc();
        busy = 1'b0; dvz = 1'b1; ovf = 1'b1; cyc();
        dvz = 1'b0; ovf = 1'b0;
        chk("dvz over ovf", g_inst[0].oe, 1);
        rdy = 1'b1; cyc(); rdy = 1'b0;
        busy = 1'b1; cyc();
        busy = 1'b0; cyc();
        chk("busy fall no flag", g_inst[0].oe, 3);
        rdy = 1'b1; cyc(); rdy = 1'b0;

        // Timeout with TMO=8, busy held 30 cycles.
        busy = 1'b1;
        cyc(8);
        chk("i1 no timeout yet", g_inst[1].oc, 0);
        cyc();
        chk("i1 timeout at 8", g_inst[1].oc, 1);
        chk("i1 timeout err", g_inst[1].oe, 3);
        cyc(21);
        chk("i1 still one entry", g_inst[1].oc, 1);
        chk("i0 still empty", g_inst[0].oc, 0);
        busy = 1'b0;
        cyc();
        chk("i1 no entry at busy fall", g_inst[1].oc, 1);
        chk("i0 busy-fall entry", g_inst[0].oe, 3);
        rdy = 1'b1; cyc(); rdy = 1'b0;

        // div_valid on the timeout cycle wins.
        busy = 1'b1; cyc();
        cyc(7);
        valid = 1'b1; quo = 10'd77;
        cyc();
        chk("i1 valid beats timeout data", g_inst[1].od, 77);
        chk("i1 valid beats timeout err", g_inst[1].oe, 0);
        valid = 1'b0; busy = 1'b0;
        cyc();
        rdy = 1'b1; cyc(); rdy = 1'b0;

        // Overflow of the FIFO and full-with-pop.
        for (int k = 1; k <= 5; k++) do_div(DW'(k), 1'b0);
        chk("full count", g_inst[0].oc, 4);
        chk("full hold", g_inst[0].oh, 1);
        chk("full lost", g_inst[0].ol, 1);
        for (int k = 1; k <= 4; k++) pop_chk(DW'(k));
        chk("drained count", g_inst[0].oc, 0);
        chk("drained hold", g_inst[0].oh, 0);
        for (int k = 10; k <= 13; k++) do_div(DW'(k), 1'b0);
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("lost cleared", g_inst[0].ol, 0);
        do_div(10'd14, 1'b1);
        chk("push+pop full count", g_inst[0].oc, 4);
        chk("push+pop no loss", g_inst[0].ol, 0);
        busy = 1'b1; cyc();
        valid = 1'b1; quo = 10'd15; clr = 1'b1;
        cyc();
        valid = 1'b0; clr = 1'b0; busy = 1'b0;
        cyc();
        chk("set beats clr_lost", g_inst[0].ol, 1);
        for (int k = 11; k <= 14; k++) pop_chk(DW'(k));
        clr = 1'b1; cyc(); clr = 1'b0;

        // Reset mid-division with two entries queued.
        do_div(10'd21, 1'b0);
        do_div(10'd22, 1'b0);
        chk("two entries", g_inst[0].oc, 2);
        busy = 1'b1;
        cyc(2);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async rst out_valid", (i == 0) ? g_inst[0].ov : g_inst[1].ov, 0);
            chk("async rst count", (i == 0) ? g_inst[0].oc : g_inst[1].oc, 0);
            chk("async rst out_data", (i == 0) ? g_inst[0].od : g_inst[1].od, 0);
        end
        cyc();
        rst = 1'b1;
        cyc(2);
        valid = 1'b1; quo = 10'd99;
        cyc();
        valid = 1'b0; busy = 1'b0;
        cyc();
        chk("in-flight ignored", g_inst[0].oc, 0);
        do_div(10'd55, 1'b0);
        chk("post-reset record count", g_inst[0].oc, 1);
        chk("post-reset record data", g_inst[0].od, 55);
        chk("post-reset record err", g_inst[0].oe, 0);
        rdy = 1'b1; cyc(2); rdy = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_result_collector.md
DIV_RESULT_COLLECTOR -- requirements
Module: div_result_collector

Interface
REQ-001 SHALL have parameter DW, default 10: quotient width.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter TMO, default 255: maximum cycles a division may stay busy.
REQ-004 SHALL have port clk  input  1: single clock, rising-edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port div_busy  input  1: divider busy flag.
REQ-007 SHALL have port div_valid  input  1: divider one-cycle result strobe.
REQ-008 SHALL have port quotient  input  DW: divider result, sampled with div_valid.
REQ-009 SHALL have ports dvz, ovf  input  1 each: divide-by-zero and overflow flags.
REQ-010 SHALL have port out_ready  input  1: consumer accepts head entry.
REQ-011 SHALL have port clr_lost  input  1: clears the lost flag.
REQ-012 SHALL have port out_valid  output  1: FIFO non-empty.
REQ-013 SHALL have port out_data  output  DW: head-entry quotient.
REQ-014 SHALL have port out_err  output  2: head-entry status; 00 ok, 01 dvz, 10 ovf, 11 timeout.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1: current occupancy.
REQ-016 SHALL have port hold  output  1: asserted when count equals DEPTH; upstream must not start.
REQ-017 SHALL have port lost  output  1: sticky flag, set when a result is dropped.

Function
REQ-018 SHALL implement monitor FSM states IDLE, RUN, DRAIN.
REQ-019 IDLE SHALL go to RUN on the first cycle div_busy=1; tmo_cnt and the err latches SHALL clear on entry.
REQ-020 In RUN, dvz or ovf high in any cycle SHALL set the sticky latch err_dvz or err_ovf respectively.
REQ-021 In RUN, div_valid=1 SHALL push {00, quotient} and go to DRAIN.
REQ-022 In RUN, div_busy=0 without div_valid SHALL push {01 if err_dvz or dvz, else 10 if err_ovf or ovf, else 11, data 0} and go to IDLE.
REQ-023 In RUN, tmo_cnt reaching TMO with no other event SHALL push {11, 0} and go to DRAIN.
REQ-024 When div_valid coincides with a timeout, div_valid SHALL take priority.
REQ-025 DRAIN SHALL go to IDLE on the first cycle div_busy=0; div_valid in DRAIN SHALL be ignored and push nothing.
REQ-026 Each division SHALL produce exactly one push.
REQ-027 The FIFO SHALL be first-word-fall-through: out_data and out_err show the head entry whenever out_valid=1.
REQ-028 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-029 A push with count=DEPTH and no same-cycle pop SHALL be dropped and SHALL set lost.
REQ-030 A push and pop in the same cycle SHALL leave count unchanged, including when full; nothing is dropped.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 Push-to-out_valid latency SHALL be 1 cycle when the FIFO is empty.
REQ-033 hold and count SHALL be registered, reflecting occupancy after the current edge.
REQ-034 lost SHALL clear only on clr_lost=1 or reset; a same-cycle set SHALL win over clr_lost.

Reset
REQ-035 rst=0 SHALL asynchronously clear the FIFO, pointers, count, tmo_cnt, the err latches and lost; out_valid, out_data, out_err, hold and lost SHALL read 0.
REQ-036 On reset release, the FSM SHALL enter DRAIN if div_busy=1, else IDLE, so a division in flight across reset is never recorded.

Verification
REQ-037 Busy 20 cycles, then div_valid with quotient=10'd37 -> one entry {00,37}; out_valid 1 cycle after the push; busy then falls -> no second entry.
REQ-038 Busy 2 cycles with dvz=1, then busy falls with no valid -> entry {01,0}.
REQ-039 TMO=8, busy held for 30 cycles -> exactly one entry {11,0} at cycle 8; the FSM stays in DRAIN until busy falls.
REQ-040 DEPTH=4, out_ready=0, five results 1..5 -> count=4, hold=1, lost=1; heads pop in order 1,2,3,4; a push on a full FIFO with a same-cycle pop keeps count=4 and leaves lost unchanged.
REQ-041 rst pulsed low mid-division with FIFO holding 2 entries -> all outputs 0 immediately; the in-flight div_valid after release is ignored; the next division records normally.
